// File: rtl/int_add_rs_if.sv
// Signal bundle between the integer add/sub reservation station and its
// dispatch, CDB, adder and CDB-arbiter neighbours.
interface int_add_rs_if #(
    parameter int TAG_W = 4
);
    logic             issue_valid;
    logic             issue_ready;
    logic             issue_op;
    logic [31:0]      issue_vj;
    logic [31:0]      issue_vk;
    logic [TAG_W-1:0] issue_qj;
    logic [TAG_W-1:0] issue_qk;
    logic [TAG_W-1:0] issue_dest;

    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_data;

    logic [31:0]      add_a;
    logic [31:0]      add_b;
    logic             add_cin;
    logic [31:0]      add_sum;
    logic             add_cout;

    logic             res_valid;
    logic             res_ready;
    logic [TAG_W-1:0] res_tag;
    logic [31:0]      res_data;
    logic             res_cout;

    modport slave (
        input  issue_valid, issue_op, issue_vj, issue_vk, issue_qj, issue_qk, issue_dest,
        output issue_ready,
        input  cdb_valid, cdb_tag, cdb_data,
        output add_a, add_b, add_cin,
        input  add_sum, add_cout,
        output res_valid, res_tag, res_data, res_cout,
        input  res_ready
    );

    modport master (
        output issue_valid, issue_op, issue_vj, issue_vk, issue_qj, issue_qk, issue_dest,
        input  issue_ready,
        output cdb_valid, cdb_tag, cdb_data,
        input  add_a, add_b, add_cin,
        output add_sum, add_cout,
        input  res_valid, res_tag, res_data, res_cout,
        output res_ready
    );
endinterface

// File: rtl/int_add_rs.sv
// Reservation station for the integer add/sub unit: buffers waiting ops, snoops
// the CDB, issues one ready op to the pipelined adder and hands the result to the CDB.
module int_add_rs #(
    parameter int NUM_ENT     = 4,
    parameter int TAG_W       = 4,
    parameter int ADD_LATENCY = 6
) (
    input  logic           clk,
    input  logic           rst,
    int_add_rs_if.slave    bus
);
    localparam int IDX_W = (NUM_ENT > 1) ? $clog2(NUM_ENT) : 1;
    localparam int CNT_W = $clog2(ADD_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    state_t             state_q, state_d;
    logic [NUM_ENT-1:0] busy_q, busy_d;
    logic [NUM_ENT-1:0] op_q, op_d;
    logic [31:0]        vj_q [NUM_ENT];
    logic [31:0]        vj_d [NUM_ENT];
    logic [31:0]        vk_q [NUM_ENT];
    logic [31:0]        vk_d [NUM_ENT];
    logic [TAG_W-1:0]   qj_q [NUM_ENT];
    logic [TAG_W-1:0]   qj_d [NUM_ENT];
    logic [TAG_W-1:0]   qk_q [NUM_ENT];
    logic [TAG_W-1:0]   qk_d [NUM_ENT];
    logic [TAG_W-1:0]   dest_q [NUM_ENT];
    logic [TAG_W-1:0]   dest_d [NUM_ENT];

    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        addA_q, addA_d, addB_q, addB_d;
    logic               addCin_q, addCin_d;
    logic               resValid_q, resValid_d;
    logic [TAG_W-1:0]   resTag_q, resTag_d;
    logic [31:0]        resData_q, resData_d;
    logic               resCout_q, resCout_d;

    logic               allocFound;
    logic [IDX_W-1:0]   allocIdx;
    logic [NUM_ENT-1:0] readyVec;
    logic               selFound;
    logic [IDX_W-1:0]   selIdx;

    assign bus.issue_ready = ~&busy_q;
    assign bus.add_a       = addA_q;
    assign bus.add_b       = addB_q;
    assign bus.add_cin     = addCin_q;
    assign bus.res_valid   = resValid_q;
    assign bus.res_tag     = resTag_q;
    assign bus.res_data    = resData_q;
    assign bus.res_cout    = resCout_q;

    // Descending scans leave the lowest matching index in the result.
    always_comb begin
        allocFound = 1'b0;
        allocIdx   = '0;
        selFound   = 1'b0;
        selIdx     = '0;
        readyVec   = '0;
        for (int i = NUM_ENT - 1; i >= 0; i--) begin
            readyVec[i] = busy_q[i] && (qj_q[i] == '0) && (qk_q[i] == '0) &&
                          !((state_q != IDLE) && (idx_q == IDX_W'(i)));
            if (!busy_q[i]) begin
                allocFound = 1'b1;
                allocIdx   = IDX_W'(i);
            end
            if (readyVec[i]) begin
                selFound = 1'b1;
                selIdx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        busy_d = busy_q;
        op_d   = op_q;
        vj_d   = vj_q;
        vk_d   = vk_q;
        qj_d   = qj_q;
        qk_d   = qk_q;
        dest_d = dest_q;
        for (int i = 0; i < NUM_ENT; i++) begin
            if (busy_q[i] && bus.cdb_valid) begin
                if ((qj_q[i] != '0) && (qj_q[i] == bus.cdb_tag)) begin
                    vj_d[i] = bus.cdb_data;
                    qj_d[i] = '0;
                end
                if ((qk_q[i] != '0) && (qk_q[i] == bus.cdb_tag)) begin
                    vk_d[i] = bus.cdb_data;
                    qk_d[i] = '0;
                end
            end
            // A new entry can pick up its operand from the broadcast it arrives with.
            if (bus.issue_valid && allocFound && (allocIdx == IDX_W'(i))) begin
                busy_d[i] = 1'b1;
                op_d[i]   = bus.issue_op;
                dest_d[i] = bus.issue_dest;
                vj_d[i]   = bus.issue_vj;
                qj_d[i]   = bus.issue_qj;
                vk_d[i]   = bus.issue_vk;
                qk_d[i]   = bus.issue_qk;
                if (bus.cdb_valid && (bus.issue_qj != '0) && (bus.issue_qj == bus.cdb_tag)) begin
                    vj_d[i] = bus.cdb_data;
                    qj_d[i] = '0;
                end
                if (bus.cdb_valid && (bus.issue_qk != '0) && (bus.issue_qk == bus.cdb_tag)) begin
                    vk_d[i] = bus.cdb_data;
                    qk_d[i] = '0;
                end
            end
            if ((state_q == WB) && bus.res_ready && (idx_q == IDX_W'(i))) begin
                busy_d[i] = 1'b0;
            end
        end
    end

    // The adder inverts b itself when cin is set, so vk goes out unmodified.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        addA_d     = addA_q;
        addB_d     = addB_q;
        addCin_d   = addCin_q;
        resValid_d = resValid_q;
        resTag_d   = resTag_q;
        resData_d  = resData_q;
        resCout_d  = resCout_q;
        case (state_q)
            IDLE: begin
                if (selFound) begin
                    addA_d   = vj_q[selIdx];
                    addB_d   = vk_q[selIdx];
                    addCin_d = op_q[selIdx];
                    idx_d    = selIdx;
                    cnt_d    = CNT_W'(ADD_LATENCY);
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == CNT_W'(1)) begin
                    resData_d  = bus.add_sum;
                    resCout_d  = bus.add_cout;
                    resTag_d   = dest_q[idx_q];
                    resValid_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = WB;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WB: begin
                if (bus.res_ready) begin
                    resValid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q     <= '0;
            op_q       <= '0;
            for (int i = 0; i < NUM_ENT; i++) begin
                vj_q[i]   <= '0;
                vk_q[i]   <= '0;
                qj_q[i]   <= '0;
                qk_q[i]   <= '0;
                dest_q[i] <= '0;
            end
            idx_q      <= '0;
            cnt_q      <= '0;
            addA_q     <= '0;
            addB_q     <= '0;
            addCin_q   <= 1'b0;
            resValid_q <= 1'b0;
            resTag_q   <= '0;
            resData_q  <= '0;
            resCout_q  <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            op_q       <= op_d;
            vj_q       <= vj_d;
            vk_q       <= vk_d;
            qj_q       <= qj_d;
            qk_q       <= qk_d;
            dest_q     <= dest_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            addA_q     <= addA_d;
            addB_q     <= addB_d;
            addCin_q   <= addCin_d;
            resValid_q <= resValid_d;
            resTag_q   <= resTag_d;
            resData_q  <= resData_d;
            resCout_q  <= resCout_d;
        end
    end
endmodule
